// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer and its decoder-side benches:
// FSM encodings, the default blanking length and the timing-counter width rule.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } scan_state_e;

    localparam int SCAN_NUM_CH           = 4;
    localparam int SCAN_CH_W             = 2;
    localparam int SCAN_BLANK_CYCLES_DEF = 2;

    // One counter times both phases, so it must hold a full dwell and a full blank.
    function automatic int scan_cnt_width(input int dwell_w);
        return (dwell_w > 4) ? dwell_w : 4;
    endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Wrap-around search for the next enabled channel strictly after cur,
// falling back to cur itself when it is the only enabled channel.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [SCAN_NUM_CH-1:0] mask,
    input  logic [SCAN_CH_W-1:0]   cur,
    output logic [SCAN_CH_W-1:0]   nxt,
    output logic                   wrap
);

    logic [SCAN_CH_W-1:0] idx;
    logic                 found;

    // Walk from the farthest candidate (cur itself) to the nearest, so the
    // nearest enabled channel above cur is the last one written.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = cur;
        for (int k = SCAN_NUM_CH; k >= 1; k--) begin
            idx = cur + SCAN_CH_W'(k);
            if (mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrap = found && (nxt <= cur);
    end

endmodule

// File: rtl/scan_sequencer.sv
// Drives a 2-to-4 decoder: walks the enabled channels, blanking the decoder
// for BLANK_CYCLES around every select change and enabling it for the dwell.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = SCAN_BLANK_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic [SCAN_NUM_CH-1:0] ch_mask,
    output logic                   a,
    output logic                   b,
    output logic                   en,
    output logic                   busy,
    output logic                   frame_done,
    output scan_state_e            dbg_state
);

    localparam int              CW         = scan_cnt_width(DWELL_W);
    localparam logic [CW-1:0]   BLANK_LOAD = CW'(BLANK_CYCLES - 1);

    scan_state_e          state_q, state_d;
    logic [SCAN_CH_W-1:0] ptr_q, ptr_d;
    logic [SCAN_CH_W-1:0] sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 fd_q, fd_d;

    logic [SCAN_CH_W-1:0] search_cur;
    logic [SCAN_CH_W-1:0] nxt_ch;
    logic                 nxt_wrap;
    logic [CW-1:0]        dwell_load;
    logic                 cnt_zero;
    logic                 go;

    // Searching "after channel 3" from IDLE yields the lowest enabled channel.
    assign search_cur = (state_q == ST_IDLE) ? SCAN_CH_W'(SCAN_NUM_CH - 1) : ptr_q;

    scan_next_ch u_next_ch (
        .mask (ch_mask),
        .cur  (search_cur),
        .nxt  (nxt_ch),
        .wrap (nxt_wrap)
    );

    assign dwell_load = (dwell == '0) ? '0 : (CW'(dwell) - CW'(1));
    assign cnt_zero   = (cnt_q == '0);
    assign go         = run && (ch_mask != '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_BLANK;
                    ptr_d   = nxt_ch;
                    sel_d   = nxt_ch;
                    cnt_d   = BLANK_LOAD;
                end
            end
            ST_BLANK: begin
                if (cnt_zero) begin
                    state_d = ST_DWELL;
                    cnt_d   = dwell_load;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DWELL: begin
                if (cnt_zero) begin
                    fd_d = nxt_wrap;
                    if (go) begin
                        state_d = ST_BLANK;
                        ptr_d   = nxt_ch;
                        sel_d   = nxt_ch;
                        cnt_d   = BLANK_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Outputs follow the next state so they change on the same edge as it.
        en_d   = (state_d != ST_DWELL);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    assign a          = sel_q[1];
    assign b          = sel_q[0];
    assign en         = en_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (BLANK_CYCLES=2): full scan, skip mask,
// single channel, stop/reset/mask-clear mid-scan, with hand-derived outputs.
module tb_scan_sequencer;
    import scan_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  dwell;
    logic [3:0]  ch_mask;
    logic        a, b, en, busy, frame_done;
    scan_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .dwell      (dwell),
        .ch_mask    (ch_mask),
        .a          (a),
        .b          (b),
        .en         (en),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {a,b,en,busy,frame_done}.
    task automatic check_out(input string tag, input logic [1:0] ch, input logic e_en,
                             input logic e_busy, input logic e_fd);
        check(tag, 32'({a, b, en, busy, frame_done}), 32'({ch, e_en, e_busy, e_fd}));
    endtask

    initial begin
        logic [1:0] ch;
        int         j;

        rst = 1'b1; run = 1'b0; dwell = 8'd0; ch_mask = 4'b0000;
        tick();
        tick();
        check_out("reset_outputs", 2'b00, 1'b1, 1'b0, 1'b0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        // Full scan: 5-clock channel period, 20-clock frame.
        rst = 1'b0; run = 1'b1; dwell = 8'd3; ch_mask = 4'b1111;
        for (int i = 0; i < 25; i++) begin
            tick();
            ch = 2'((i / 5) % 4);
            j  = i % 5;
            check_out($sformatf("full_scan i=%0d", i), ch, (j < 2), 1'b1,
                      (i > 0) && (i % 20 == 0));
        end

        // Skip mask 1010, dwell 1: channels 1,3 with 3-clock period.
        rst = 1'b1;
        tick();
        rst = 1'b0; dwell = 8'd1; ch_mask = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            tick();
            ch = ((i / 3) % 2 == 0) ? 2'd1 : 2'd3;
            j  = i % 3;
            check_out($sformatf("skip i=%0d", i), ch, (j != 2), 1'b1,
                      (i > 0) && (i % 6 == 0));
        end

        // Single channel 2, dwell 0 treated as 1: wraps after every dwell.
        rst = 1'b1;
        tick();
        rst = 1'b0; dwell = 8'd0; ch_mask = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            tick();
            j = i % 3;
            check_out($sformatf("single i=%0d", i), 2'd2, (j != 2), 1'b1,
                      (i > 0) && (i % 3 == 0));
        end
        // Stopping at a wrapping dwell end still pulses frame_done.
        run = 1'b0;
        tick();
        check_out("single_stop_wrap", 2'd2, 1'b1, 1'b0, 1'b1);
        tick();
        check_out("single_stop_idle", 2'd2, 1'b1, 1'b0, 1'b0);

        // Stop mid-dwell on channel 2 with dwell 5; dwell change ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1; dwell = 8'd5; ch_mask = 4'b1111;
        for (int i = 0; i < 18; i++) begin
            tick();
            ch = 2'(i / 7);
            j  = i % 7;
            check_out($sformatf("stop_run i=%0d", i), ch, (j < 2), 1'b1, 1'b0);
        end
        run = 1'b0; dwell = 8'd1;
        for (int i = 18; i < 21; i++) begin
            tick();
            check_out($sformatf("stop_hold i=%0d", i), 2'd2, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check_out("stop_idle", 2'd2, 1'b1, 1'b0, 1'b0);
        check("stop_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check_out("stop_idle_hold", 2'd2, 1'b1, 1'b0, 1'b0);

        // Reset during channel 1 dwell, then restart with run held high.
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1; dwell = 8'd3; ch_mask = 4'b1111;
        for (int i = 0; i < 8; i++) tick();
        check_out("pre_reset_dwell", 2'd1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_out("mid_dwell_reset", 2'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_out("restart_blank0", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("restart_blank1", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("restart_dwell", 2'd0, 1'b0, 1'b1, 1'b0);

        // Mask cleared mid-blank: current dwell completes, then IDLE and stays.
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1; dwell = 8'd2; ch_mask = 4'b1111;
        tick();
        check_out("mask0_blank0", 2'd0, 1'b1, 1'b1, 1'b0);
        ch_mask = 4'b0000;
        tick();
        check_out("mask0_blank1", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("mask0_dwell0", 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("mask0_dwell1", 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("mask0_idle", 32'({a, b, en, busy}), 32'(4'b0010));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("mask0_stay i=%0d", i), 2'd0, 1'b1, 1'b0, 1'b0);
        end
        ch_mask = 4'b0010;
        tick();
        check_out("mask_restore", 2'd1, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 8: width of the dwell-length input.
REQ-002 Parameter BLANK_CYCLES, default 2, legal range 1..15: select-change blanking length, in clocks.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 run  input  1  level; 1 = scan enabled.
REQ-006 dwell  input  DWELL_W  per-channel on-time, in clocks; 0 is treated as 1.
REQ-007 ch_mask  input  4  per-channel enable; bit i = channel i participates.
REQ-008 a  output  1  decoder select MSB (channel index = {a,b}).
REQ-009 b  output  1  decoder select LSB.
REQ-010 en  output  1  decoder enable, active-low (0 = decoder output active).
REQ-011 busy  output  1  1 whenever state is not IDLE.
REQ-012 frame_done  output  1  one-clock pulse when the scan wraps past the last enabled channel.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 FSM states SHALL be IDLE, BLANK and DWELL; en=0 only in DWELL, en=1 in IDLE and BLANK.
- IDLE: a,b hold their last value (0 after reset).
REQ-015 IDLE -> BLANK SHALL occur when run=1 and ch_mask!=0 are sampled.
- ptr loads the lowest set bit of ch_mask.
- a,b take ptr in the first BLANK cycle.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES clocks with a,b stable, then go to DWELL.
REQ-017 On DWELL entry, dwell SHALL be sampled; DWELL SHALL last max(dwell,1) clocks.
- Changes to dwell during DWELL have no effect until the next entry.
REQ-018 At the end of DWELL, next ptr SHALL be the next set bit of the current ch_mask above ptr.
- Search wraps 3->0 and may return ptr itself.
- Next state: BLANK.
REQ-019 frame_done SHALL pulse for exactly one clock, in the first cycle after the DWELL end, when the advance wraps (next ptr <= current ptr).
- Covers the single-channel case, which pulses after every dwell.
REQ-020 If run=0 or ch_mask=0 at the end of DWELL, the next state SHALL be IDLE.
- frame_done still pulses if the advance would have wrapped.
- run deasserted mid-DWELL or mid-BLANK never truncates the current dwell or blank.
REQ-021 Latency: run sampled high at edge N -> BLANK at N+1 -> en=0 first at edge N+1+BLANK_CYCLES.
REQ-022 There SHALL be no gap cycles.
- Channel period = BLANK_CYCLES + max(dwell,1) clocks.
REQ-023 Select lines SHALL never change in the same cycle as en=0, so the decoder never sees a glitched index while enabled.

Reset
REQ-024 With rst=1 at an edge, the next cycle SHALL show: state IDLE, ptr=0, a=0, b=0, en=1, busy=0, frame_done=0, counters 0.
REQ-025 rst SHALL take priority over all other inputs, including mid-DWELL and mid-BLANK.
- Scanning resumes only via REQ-015.

Structure
REQ-026 FSM state encodings and the BLANK_CYCLES default SHALL live in a shared package/include, scan_pkg, reused by the decoder bench.
REQ-027 The wrap-around next-set-bit search SHALL be one combinational sub-module, scan_next_ch.
- Inputs: mask[3:0], cur[1:0]. Outputs: nxt[1:0], wrap.
REQ-028 One shared down-counter (width max(DWELL_W,4)) SHALL serve both BLANK and DWELL timing.

Verification
REQ-029 Full scan: mask=4'b1111, dwell=3, run=1.
- a,b sequence 00,01,10,11,00.
- Each channel: 2 clocks en=1, then 3 clocks en=0.
- frame_done pulses once per 20-clock frame.
REQ-030 Skip: mask=4'b1010, dwell=1.
- Channels 1 and 3 only.
- frame_done pulses on each 3->1 advance.
REQ-031 Single channel / dwell=0: mask=4'b0100, dwell=0.
- a,b fixed at 10; en pattern 1,1,0 repeating.
- frame_done pulses every 3 clocks.
REQ-032 Stop mid-dwell: run drops during channel 2 DWELL with dwell=5.
- All 5 en=0 cycles complete, then IDLE with en=1, busy=0.
REQ-033 Reset mid-DWELL: rst=1 for one clock.
- Next cycle a=0, b=0, en=1, busy=0, frame_done=0.
- With run still 1, restart per REQ-021.
REQ-034 Mask zeroed mid-BLANK: mask=0 takes effect at the next DWELL end -> IDLE.
- IDLE is not re-exited while mask=0.
